// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the byte-serial shared-adder arbiter.
package adder_seq_pkg;
  localparam int BYTE_W = 8;
  localparam int NREQ   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/prefix_add8_cin.sv
// Combinational 8-bit Sklansky prefix adder with carry-in and carry-out.
module prefix_add8_cin
  import adder_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              cin_i,
  output logic [BYTE_W-1:0] sum_o,
  output logic              cout_o
);
  localparam int LVL = $clog2(BYTE_W);

  logic [BYTE_W-1:0] p0;
  logic [BYTE_W-1:0] g_l [0:LVL];
  logic [BYTE_W-1:0] p_l [0:LVL-1];

  assign p0 = a_i ^ b_i;
  // Carry-in is folded into bit 0's generate, so g_l[LVL][i] is the carry into bit i+1.
  assign g_l[0] = (a_i & b_i) | {{(BYTE_W-1){1'b0}}, p0[0] & cin_i};
  assign p_l[0] = p0;

  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
      localparam int J = ((i >> k) << k) - 1;
      if (((i >> k) & 1) == 1) begin : g_cell
        assign g_l[k+1][i] = g_l[k][i] | (p_l[k][i] & g_l[k][J]);
        if (k < LVL - 1) begin : g_pout
          if (i < (2 << k)) begin : g_gray
            assign p_l[k+1][i] = p_l[k][i];
          end else begin : g_black
            assign p_l[k+1][i] = p_l[k][i] & p_l[k][J];
          end
        end
      end else begin : g_pass
        assign g_l[k+1][i] = g_l[k][i];
        if (k < LVL - 1) begin : g_pout
          assign p_l[k+1][i] = p_l[k][i];
        end
      end
    end
  end

  assign sum_o  = p0 ^ {g_l[LVL][BYTE_W-2:0], cin_i};
  assign cout_o = g_l[LVL][BYTE_W-1];
endmodule

// File: rtl/adder_arbiter_seq.sv
// Round-robin packet arbiter sharing one prefix adder between two byte-serial requesters.
// Define ADDER_SUB_EN to add per-requester in_sub (A-B via inverted B and first-beat carry-in).
module adder_arbiter_seq
  import adder_seq_pkg::*;
#(
  parameter  int MAX_BYTES = 8,
  localparam int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          in_valid,
  output logic [NREQ-1:0]          in_ready,
  input  logic [NREQ*BYTE_W-1:0]   in_a,
  input  logic [NREQ*BYTE_W-1:0]   in_b,
  input  logic [NREQ-1:0]          in_last,
`ifdef ADDER_SUB_EN
  input  logic [NREQ-1:0]          in_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W-1:0]        out_sum,
  output logic                     out_last,
  output logic                     out_carry,
  output logic                     out_id,
  output logic                     out_err,
  output state_t                   dbg_state,
  output logic                     dbg_rr
);
  // Handshake: a beat moves on a cycle where valid and ready are both high at the
  // rising edge; valid never waits for ready, and in_ready never looks at in_valid.
  state_t            state_q;
  logic              grant_q, rr_q, carry_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_last_q, out_carry_q, out_id_q, out_err_q;
  logic [BYTE_W-1:0] out_sum_q;

  logic [BYTE_W-1:0] a_sel, b_sel, b_eff, sum_d;
  logic              last_sel, sub_sel, cin_d, carry_d, beat_acc, out_free;
  logic [NREQ-1:0]   grant_oh;

  assign out_free = ~out_valid_q | out_ready;
  assign grant_oh = grant_q ? 2'b10 : 2'b01;

  always_comb begin
    in_ready = '0;
    if (!rst && ((state_q == BUSY && out_free) || state_q == DRAIN))
      in_ready = grant_oh;
  end

  assign beat_acc = |(in_valid & in_ready);

  always_comb begin
    a_sel    = grant_q ? in_a[2*BYTE_W-1:BYTE_W] : in_a[BYTE_W-1:0];
    b_sel    = grant_q ? in_b[2*BYTE_W-1:BYTE_W] : in_b[BYTE_W-1:0];
    last_sel = grant_q ? in_last[1] : in_last[0];
`ifdef ADDER_SUB_EN
    sub_sel  = grant_q ? in_sub[1] : in_sub[0];
`else
    sub_sel  = 1'b0;
`endif
    b_eff    = sub_sel ? ~b_sel : b_sel;
    // First beat seeds the chain (1 for subtract); later beats use the stored carry.
    cin_d    = (cnt_q == '0) ? sub_sel : carry_q;
    cnt_d    = cnt_q + CNT_W'(1);
  end

  prefix_add8_cin u_add (
    .a_i   (a_sel),
    .b_i   (b_eff),
    .cin_i (cin_d),
    .sum_o (sum_d),
    .cout_o(carry_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      rr_q        <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|in_valid) begin
            grant_q <= in_valid[rr_q] ? rr_q : ~rr_q;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (beat_acc) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= sum_d;
            out_id_q    <= grant_q;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            if (last_sel) begin
              out_last_q  <= 1'b1;
              out_carry_q <= carry_d;
              out_err_q   <= 1'b0;
              rr_q        <= ~grant_q;
              state_q     <= IDLE;
            end else if (cnt_d == CNT_W'(MAX_BYTES)) begin
              out_last_q  <= 1'b1;
              out_carry_q <= carry_d;
              out_err_q   <= 1'b1;
              state_q     <= DRAIN;
            end else begin
              out_last_q  <= 1'b0;
              out_carry_q <= 1'b0;
              out_err_q   <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Overlong tail is swallowed until the requester's own last beat.
          if (beat_acc && last_sel) begin
            rr_q    <= ~grant_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_carry = out_carry_q;
  assign out_id    = out_id_q;
  assign out_err   = out_err_q;
  assign dbg_state = state_q;
  assign dbg_rr    = rr_q;
endmodule
